// File: rtl/arb_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 64;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog for the arbiter: counts BUSY cycles without MemAck and
// raises a sticky error when the limit is hit. Only built under ARB_TIMEOUT_EN.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_busy,
    input  logic i_ack,
    output logic o_expire,
    output logic o_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_wait;

    assign w_wait   = i_busy & ~i_ack;
    // Fires on the TIMEOUT-th unacknowledged BUSY cycle.
    assign o_expire = w_wait & (r_cnt == LIMIT);
    assign o_err    = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_start || o_expire) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_expire) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises F-stage fetches and M-stage data accesses onto one memory port.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReqF,
    input  logic [ADDR_W-1:0] IAdrF,
    output logic [DATA_W-1:0] IRdataF,
    output logic              IReadyF,
    input  logic              DReqM,
    input  logic              DWeM,
    input  logic [ADDR_W-1:0] DAdrM,
    input  logic [DATA_W-1:0] DWdataM,
    output logic [DATA_W-1:0] DRdataM,
    output logic              DReadyM,
    output logic              MemStallF,
    output logic              MemStallM,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAdr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemAck,
    output logic              MemErr,
    output arb_state_t        DbgState
);

    // Handshake: MemReq and the Mem* fields are held stable from issue until
    // the single-cycle MemAck pulse; MemAck outside a BUSY state is ignored.
    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_busy;
    logic w_start;
    logic w_expire;
    logic w_err;

    assign w_busy  = (r_state != ARB_IDLE);
    assign w_start = (r_state == ARB_IDLE) & (DReqM | IReqF);

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_busy   (w_busy),
        .i_ack    (MemAck),
        .o_expire (w_expire),
        .o_err    (w_err)
    );
`else
    assign w_expire = 1'b0;
    assign w_err    = 1'b0;
    // TIMEOUT only matters when the watchdog is built in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // Data accesses take priority over fetches.
                    if (DReqM) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= DWeM;
                        r_mem_adr   <= DAdrM;
                        r_mem_wdata <= DWdataM;
                        r_state     <= ARB_BUSY_D;
                    end else if (IReqF) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_mem_adr <= IAdrF;
                        r_state   <= ARB_BUSY_I;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (MemAck || w_expire) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    // A redirected or dropped fetch completes on the bus but is never reported.
    assign IReadyF   = (r_state == ARB_BUSY_I) & MemAck & IReqF & (IAdrF == r_mem_adr);
    assign DReadyM   = (r_state == ARB_BUSY_D) & MemAck & DReqM;
    assign IRdataF   = MemRdata;
    assign DRdataM   = MemRdata;
    assign MemStallF = IReqF & ~IReadyF;
    assign MemStallM = DReqM & ~DReadyM;

    assign MemReq   = r_mem_req;
    assign MemWe    = r_mem_we;
    assign MemAdr   = r_mem_adr;
    assign MemWdata = r_mem_wdata;
    assign MemErr   = w_err;
    assign DbgState = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; watchdog checks follow ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req_f;
    logic [AW-1:0] i_adr_f;
    logic [DW-1:0] i_rdata_f;
    logic          i_ready_f;
    logic          d_req_m;
    logic          d_we_m;
    logic [AW-1:0] d_adr_m;
    logic [DW-1:0] d_wdata_m;
    logic [DW-1:0] d_rdata_m;
    logic          d_ready_m;
    logic          stall_f;
    logic          stall_m;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;
    arb_state_t    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .IReqF     (i_req_f),
        .IAdrF     (i_adr_f),
        .IRdataF   (i_rdata_f),
        .IReadyF   (i_ready_f),
        .DReqM     (d_req_m),
        .DWeM      (d_we_m),
        .DAdrM     (d_adr_m),
        .DWdataM   (d_wdata_m),
        .DRdataM   (d_rdata_m),
        .DReadyM   (d_ready_m),
        .MemStallF (stall_f),
        .MemStallM (stall_m),
        .MemReq    (mem_req),
        .MemWe     (mem_we),
        .MemAdr    (mem_adr),
        .MemWdata  (mem_wdata),
        .MemRdata  (mem_rdata),
        .MemAck    (mem_ack),
        .MemErr    (mem_err),
        .DbgState  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Inputs change 1ns after the edge; checks run 1ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        i_req_f   = 1'b0;
        i_adr_f   = '0;
        d_req_m   = 1'b0;
        d_we_m    = 1'b0;
        d_adr_m   = '0;
        d_wdata_m = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic drive_fetch(input logic [AW-1:0] adr);
        i_req_f = 1'b1;
        i_adr_f = adr;
    endtask

    task automatic drive_data(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        d_req_m   = 1'b1;
        d_we_m    = we;
        d_adr_m   = adr;
        d_wdata_m = wd;
    endtask

    task automatic ack(input logic [DW-1:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        drive_idle();
        apply_reset();
        settle();
        chk("rst_req",   32'(mem_req),   32'h0);
        chk("rst_we",    32'(mem_we),    32'h0);
        chk("rst_adr",   mem_adr,        32'h0);
        chk("rst_wdata", mem_wdata,      32'h0);
        chk("rst_err",   32'(mem_err),   32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Fetch only: issue, one wait cycle, ack.
        drive_fetch(32'h100);
        settle();
        chk("f_stall0",  32'(stall_f),   32'h1);
        chk("f_rdy0",    32'(i_ready_f), 32'h0);
        tick();
        settle();
        chk("f_req",     32'(mem_req),   32'h1);
        chk("f_adr",     mem_adr,        32'h100);
        chk("f_we",      32'(mem_we),    32'h0);
        chk("f_stall1",  32'(stall_f),   32'h1);
        tick();
        ack(32'hE3A01005);
        settle();
        chk("f_rdy",     32'(i_ready_f), 32'h1);
        chk("f_rdata",   i_rdata_f,      32'hE3A01005);
        chk("f_stall2",  32'(stall_f),   32'h0);
        tick();
        drive_idle();
        settle();
        chk("f_done_req",   32'(mem_req),   32'h0);
        chk("f_done_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Simultaneous store and fetch: data first, one IDLE cycle, then fetch.
        drive_fetch(32'h104);
        drive_data(1'b1, 32'h200, 32'hDEADBEEF);
        settle();
        chk("s_stall_f0", 32'(stall_f), 32'h1);
        chk("s_stall_m0", 32'(stall_m), 32'h1);
        tick();
        ack(32'h0);
        settle();
        chk("s_state_d",  32'(dbg_state), 32'(ARB_BUSY_D));
        chk("s_we",       32'(mem_we),    32'h1);
        chk("s_adr",      mem_adr,        32'h200);
        chk("s_wdata",    mem_wdata,      32'hDEADBEEF);
        chk("s_drdy",     32'(d_ready_m), 32'h1);
        chk("s_stall_m1", 32'(stall_m),   32'h0);
        chk("s_stall_f1", 32'(stall_f),   32'h1);
        chk("s_irdy1",    32'(i_ready_f), 32'h0);
        tick();
        d_req_m = 1'b0;
        mem_ack = 1'b0;
        settle();
        chk("s_gap_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("s_gap_req",   32'(mem_req),   32'h0);
        chk("s_stall_f2",  32'(stall_f),   32'h1);
        tick();
        settle();
        chk("s_i_req",    32'(mem_req),   32'h1);
        chk("s_i_adr",    mem_adr,        32'h104);
        chk("s_i_we",     32'(mem_we),    32'h0);
        chk("s_stall_f3", 32'(stall_f),   32'h1);
        ack(32'h12345678);
        settle();
        chk("s_irdy",     32'(i_ready_f), 32'h1);
        chk("s_irdata",   i_rdata_f,      32'h12345678);
        tick();
        drive_idle();

        // Fetch redirect 0x100 -> 0x300 while BUSY_I.
        drive_fetch(32'h100);
        tick();
        i_adr_f = 32'h300;
        settle();
        chk("r_adr_held", mem_adr,        32'h100);
        chk("r_state_i",  32'(dbg_state), 32'(ARB_BUSY_I));
        tick();
        ack(32'h11111111);
        settle();
        chk("r_no_rdy",   32'(i_ready_f), 32'h0);
        chk("r_stall",    32'(stall_f),   32'h1);
        tick();
        mem_ack = 1'b0;
        settle();
        chk("r_idle",     32'(dbg_state), 32'(ARB_IDLE));
        chk("r_idle_req", 32'(mem_req),   32'h0);
        tick();
        settle();
        chk("r_req2",     32'(mem_req),   32'h1);
        chk("r_adr2",     mem_adr,        32'h300);
        ack(32'h22222222);
        settle();
        chk("r_rdy2",     32'(i_ready_f), 32'h1);
        chk("r_rdata2",   i_rdata_f,      32'h22222222);
        tick();
        drive_idle();

        // Load whose request drops before the ack: no DReadyM.
        drive_data(1'b0, 32'h400, 32'h0);
        tick();
        d_req_m = 1'b0;
        ack(32'h33333333);
        settle();
        chk("dd_state",  32'(dbg_state), 32'(ARB_BUSY_D));
        chk("dd_no_rdy", 32'(d_ready_m), 32'h0);
        chk("dd_stall",  32'(stall_m),   32'h0);
        tick();
        drive_idle();

        // Stray MemAck in IDLE.
        ack(32'h44444444);
        settle();
        chk("ia_irdy", 32'(i_ready_f), 32'h0);
        chk("ia_drdy", 32'(d_ready_m), 32'h0);
        tick();
        drive_idle();
        settle();
        chk("ia_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("ia_req",   32'(mem_req),   32'h0);

        // Reset while BUSY_D abandons the store.
        drive_data(1'b1, 32'h500, 32'hCAFEF00D);
        tick();
        settle();
        chk("rm_req_busy", 32'(mem_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_idle();
        settle();
        chk("rm_req",   32'(mem_req),   32'h0);
        chk("rm_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("rm_we",    32'(mem_we),    32'h0);
        chk("rm_adr",   mem_adr,        32'h0);
        chk("rm_wdata", mem_wdata,      32'h0);

        // Memory never acknowledges.
        drive_data(1'b0, 32'h600, 32'h0);
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wd_busy_req", 32'(mem_req), 32'h1);
            chk("wd_busy_err", 32'(mem_err), 32'h0);
            tick();
        end
        d_req_m = 1'b0;
        settle();
        chk("wd_err",   32'(mem_err),   32'h1);
        chk("wd_req",   32'(mem_req),   32'h0);
        chk("wd_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("wd_drdy",  32'(d_ready_m), 32'h0);
        tick();
        tick();
        settle();
        chk("wd_sticky", 32'(mem_err), 32'h1);
        apply_reset();
        settle();
        chk("wd_err_clr", 32'(mem_err), 32'h0);
`else
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("nw_req",   32'(mem_req),   32'h1);
            chk("nw_err",   32'(mem_err),   32'h0);
            chk("nw_stall", 32'(stall_m),   32'h1);
            tick();
        end
        ack(32'h55555555);
        settle();
        chk("nw_state", 32'(dbg_state), 32'(ARB_BUSY_D));
        chk("nw_drdy",  32'(d_ready_m), 32'h1);
        chk("nw_rdata", d_rdata_m,      32'h55555555);
        tick();
        drive_idle();
        settle();
        chk("nw_done", 32'(mem_req), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (F) and the memory stage (M) of the pipelined ARM core.
- Serialises accesses with a 3-state FSM and drives a MemReq/MemAck handshake to memory.
- Produces per-stage memory stalls that the hazard unit ORs into StallF and the M-stage stall.
- Data accesses have priority over fetches.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- IReqF  in  1  fetch request (level).
- IAdrF  in  ADDR_W  fetch address.
- IRdataF  out  DATA_W  fetch data; valid while IReadyF.
- IReadyF  out  1  fetch complete this cycle.
- DReqM  in  1  data request (level).
- DWeM  in  1  1 = store.
- DAdrM  in  ADDR_W  data address.
- DWdataM  in  DATA_W  store data.
- DRdataM  out  DATA_W  load data; valid while DReadyM.
- DReadyM  out  1  data access complete this cycle.
- MemStallF  out  1  IReqF & ~IReadyF.
- MemStallM  out  1  DReqM & ~DReadyM.
- MemReq  out  1  registered request to memory.
- MemWe  out  1  registered write enable.
- MemAdr  out  ADDR_W  registered address.
- MemWdata  out  DATA_W  registered write data.
- MemRdata  in  DATA_W  memory read data; valid with MemAck.
- MemAck  in  1  memory completion, one-cycle pulse.
- MemErr  out  1  watchdog error, sticky (ARB_TIMEOUT_EN only).

Behaviour:
- States: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D. Reset enters ARB_IDLE.
- Reset values: MemReq=0, MemWe=0, MemAdr=0, MemWdata=0, MemErr=0, all internal latches 0.
- Reset is honoured mid-transaction: MemReq=0 on the next cycle and the outstanding access is abandoned. Memory shares the same reset.
- ARB_IDLE:
  - DReqM=1: latch DAdrM/DWeM/DWdataM into Mem* registers, set MemReq=1, go to ARB_BUSY_D.
  - Else IReqF=1: latch IAdrF, MemWe=0, MemReq=1, go to ARB_BUSY_I.
  - DReqM and IReqF together: data wins; fetch waits (MemStallF=1).
- ARB_BUSY_*:
  - MemReq and the Mem* fields stay stable until MemAck.
  - On the MemAck cycle: MemReq deasserts next edge and the state returns to ARB_IDLE. This gives exactly one arbitration cycle between accesses.
- Ready (combinational):
  - DReadyM = (state==ARB_BUSY_D) & MemAck & DReqM.
  - IReadyF = (state==ARB_BUSY_I) & MemAck & IReqF & (IAdrF==latched address).
  - IRdataF = DRdataM = MemRdata.
- Minimum access latency: 2 cycles (request seen in IDLE, MemAck on the first BUSY cycle).
- Ready-only outputs are 0 in IDLE; MemStall* are therefore 1 for any active request in IDLE.
- Fetch redirect mid-access (IAdrF changes or IReqF drops in ARB_BUSY_I):
  - The access still completes and its data is discarded; no IReadyF.
  - A new fetch issues from ARB_IDLE.
- DReqM dropping in ARB_BUSY_D: the access completes (stores are committed) and DReadyM is suppressed.
- MemAck while in ARB_IDLE: ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ARB_BUSY_* and counts each BUSY cycle without MemAck.
  - When the counter reaches TIMEOUT: set MemErr (sticky until reset), drop MemReq, return to ARB_IDLE. No Ready is given, so the requester re-requests.
- Undefined: no counter, MemErr tied to 0, and the FSM waits indefinitely for MemAck.

Decomposition:
- Package arb_pkg holds:
  - typedef arb_state_t (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D);
  - the default widths.
- Sub-module arb_watchdog (counter plus sticky error) is instantiated only under ARB_TIMEOUT_EN.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Fetch only: IReqF=1, IAdrF=0x100, memory acks one cycle after MemReq with 0xE3A01005 -> MemReq/MemAdr=0x100 one cycle later; IReadyF=1 with IRdataF=0xE3A01005 on the ack cycle; MemStallF=1 on the two prior cycles.
- Simultaneous requests: IReqF=1 and DReqM=1 (store, DAdrM=0x200, DWdataM=0xDEADBEEF) -> data served first with MemWe=1, MemAdr=0x200; then one ARB_IDLE cycle; then fetch issued; MemStallF held throughout.
- Fetch redirect: IAdrF changes 0x100->0x300 while in ARB_BUSY_I -> no IReadyF on that ack; a second MemReq issues with MemAdr=0x300 and completes with IReadyF.
- Reset mid-access: assert reset in ARB_BUSY_D -> next cycle MemReq=0, state ARB_IDLE, all Mem* fields=0.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT=4): no MemAck -> MemErr=1 after 4 BUSY cycles, MemReq=0, MemErr stays 1 until reset; without the macro, MemReq stays 1 indefinitely.
